// File: rtl/move_controller_if.sv
// Drop-request channel between the move controller and board storage.
interface move_controller_if #(
    parameter int COL_W = 3,
    parameter int ROW_W = 3
);
    logic             drop_valid;
    logic             drop_ready;
    logic [COL_W-1:0] drop_col;
    logic [ROW_W-1:0] drop_row;
    logic             drop_player;

    modport master (output drop_valid, drop_col, drop_row, drop_player, input drop_ready);
    modport slave  (input drop_valid, drop_col, drop_row, drop_player, output drop_ready);
endinterface

// File: rtl/move_controller.sv
// Connect-4 move controller: cursor, column heights, turn tracking and drop requests.
// Optional macro MOVE_CONTROLLER_RECENTER_EN returns the cursor to START_COL after every drop.
module move_controller #(
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int COL_W     = 3,
    parameter int ROW_W     = 3,
    parameter int START_COL = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left_pulse,
    input  logic             right_pulse,
    input  logic             confirm_pulse,
    input  logic             new_game,
    input  logic             game_over_in,
    output logic [COL_W-1:0] cursor_col,
    output logic             player,
    output logic             col_full_err,
    output logic             board_full,
    move_controller_if.master drop
);

    localparam int TOTAL = COLS * ROWS;
    localparam int MC_W  = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {SELECT, ISSUE, TURN, DRAW, HALT} state_t;

    state_t           state, state_n;
    logic [COL_W-1:0] cursor_q, cursor_n;
    logic             player_q, player_n;
    logic             dv_q, dv_n;
    logic [COL_W-1:0] dc_q, dc_n;
    logic [ROW_W-1:0] dr_q, dr_n;
    logic             dp_q, dp_n;
    logic             err_q, err_n;
    logic             bf_q, bf_n;
    logic [MC_W-1:0]  count_q, count_n;
    logic [ROW_W-1:0] heights   [COLS];
    logic [ROW_W-1:0] heights_n [COLS];

    logic [MC_W-1:0]  count_inc;
    logic             sel_full;
    logic [COL_W-1:0] cursor_left, cursor_right;

    assign count_inc    = count_q + MC_W'(1);
    assign sel_full     = (heights[cursor_q] == ROW_W'(ROWS));
    assign cursor_left  = (cursor_q == '0) ? COL_W'(COLS - 1) : cursor_q - COL_W'(1);
    assign cursor_right = (cursor_q == COL_W'(COLS - 1)) ? '0 : cursor_q + COL_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SELECT;
            cursor_q <= COL_W'(START_COL);
            player_q <= 1'b0;
            dv_q     <= 1'b0;
            dc_q     <= '0;
            dr_q     <= '0;
            dp_q     <= 1'b0;
            err_q    <= 1'b0;
            bf_q     <= 1'b0;
            count_q  <= '0;
            for (int i = 0; i < COLS; i++) heights[i] <= '0;
        end else begin
            state    <= state_n;
            cursor_q <= cursor_n;
            player_q <= player_n;
            dv_q     <= dv_n;
            dc_q     <= dc_n;
            dr_q     <= dr_n;
            dp_q     <= dp_n;
            err_q    <= err_n;
            bf_q     <= bf_n;
            count_q  <= count_n;
            heights  <= heights_n;
        end
    end

    always_comb begin
        state_n = state;
        if (new_game) begin
            state_n = SELECT;
        end else begin
            unique case (state)
                SELECT: begin
                    if (game_over_in)                   state_n = HALT;
                    else if (confirm_pulse && !sel_full) state_n = ISSUE;
                end
                ISSUE:  if (dv_q && drop.drop_ready) state_n = TURN;
                TURN: begin
                    if (count_inc == MC_W'(TOTAL)) state_n = DRAW;
                    else if (game_over_in)         state_n = HALT;
                    else                           state_n = SELECT;
                end
                default: state_n = state;
            endcase
        end
    end

    // Next values for every registered output; board_full simply mirrors the DRAW state.
    always_comb begin
        cursor_n  = cursor_q;
        player_n  = player_q;
        dv_n      = dv_q;
        dc_n      = dc_q;
        dr_n      = dr_q;
        dp_n      = dp_q;
        err_n     = 1'b0;
        count_n   = count_q;
        heights_n = heights;
        bf_n      = (state_n == DRAW);
        if (new_game) begin
            cursor_n = COL_W'(START_COL);
            player_n = 1'b0;
            dv_n     = 1'b0;
            dc_n     = '0;
            dr_n     = '0;
            dp_n     = 1'b0;
            count_n  = '0;
            for (int i = 0; i < COLS; i++) heights_n[i] = '0;
        end else begin
            unique case (state)
                SELECT: begin
                    if (!game_over_in) begin
                        if (confirm_pulse) begin
                            if (sel_full) begin
                                err_n = 1'b1;
                            end else begin
                                dc_n = cursor_q;
                                dr_n = heights[cursor_q];
                                dp_n = player_q;
                                dv_n = 1'b1;
                            end
                        end else if (left_pulse ^ right_pulse) begin
                            cursor_n = left_pulse ? cursor_left : cursor_right;
                        end
                    end
                end
                ISSUE: if (dv_q && drop.drop_ready) dv_n = 1'b0;
                TURN: begin
                    if (heights[dc_q] != ROW_W'(ROWS)) heights_n[dc_q] = heights[dc_q] + ROW_W'(1);
                    if (count_q != MC_W'(TOTAL)) count_n = count_inc;
                    player_n = ~player_q;
`ifdef MOVE_CONTROLLER_RECENTER_EN
                    cursor_n = COL_W'(START_COL);
`else
                    cursor_n = cursor_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign cursor_col       = cursor_q;
    assign player           = player_q;
    assign col_full_err     = err_q;
    assign board_full       = bf_q;
    assign drop.drop_valid  = dv_q;
    assign drop.drop_col    = dc_q;
    assign drop.drop_row    = dr_q;
    assign drop.drop_player = dp_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed vector table, hand sequences and randomized run against a game model.
module tb_move_controller;

    localparam int COLS      = 7;
    localparam int ROWS      = 6;
    localparam int START_COL = 3;
    localparam int P_SEL = 0, P_ISS = 1, P_TRN = 2, P_DRAW = 3, P_HALT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       left_pulse, right_pulse, confirm_pulse, new_game, game_over_in;
    logic [2:0] cursor_col;
    logic       player, col_full_err, board_full;

    move_controller_if #(.COL_W(3), .ROW_W(3)) dif ();

    move_controller dut (
        .clk          (clk),
        .reset        (reset),
        .left_pulse   (left_pulse),
        .right_pulse  (right_pulse),
        .confirm_pulse(confirm_pulse),
        .new_game     (new_game),
        .game_over_in (game_over_in),
        .cursor_col   (cursor_col),
        .player       (player),
        .col_full_err (col_full_err),
        .board_full   (board_full),
        .drop         (dif)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Game model: plain per-column counts and a phase number
    int m_h [COLS];
    int m_cur, m_pl, m_dv, m_dc, m_dr, m_dp, m_err, m_cnt, m_phase;

    typedef struct {
        bit l, r, c, ng, go, rdy;
        int cur, pl, dv, err, bf, dc, dr, dp;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(bit l, bit r, bit c, bit ng, bit go, bit rdy,
                                int cur, int pl, int dv, int err, int bf, int dc, int dr, int dp);
        vec_t v;
        v.l = l; v.r = r; v.c = c; v.ng = ng; v.go = go; v.rdy = rdy;
        v.cur = cur; v.pl = pl; v.dv = dv; v.err = err; v.bf = bf;
        v.dc = dc; v.dr = dr; v.dp = dp;
        return v;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < COLS; i++) m_h[i] = 0;
        m_cur = START_COL; m_pl = 0; m_dv = 0; m_dc = 0; m_dr = 0; m_dp = 0;
        m_err = 0; m_cnt = 0; m_phase = P_SEL;
    endfunction

    function automatic void modelStep(bit l, bit r, bit c, bit ng, bit go, bit rdy);
        m_err = 0;
        if (ng) begin
            modelReset();
            return;
        end
        case (m_phase)
            P_SEL: begin
                if (go) m_phase = P_HALT;
                else if (c) begin
                    if (m_h[m_cur] == ROWS) m_err = 1;
                    else begin
                        m_dc = m_cur; m_dr = m_h[m_cur]; m_dp = m_pl; m_dv = 1;
                        m_phase = P_ISS;
                    end
                end else if (l && !r) m_cur = (m_cur + COLS - 1) % COLS;
                else if (r && !l)     m_cur = (m_cur + 1) % COLS;
            end
            P_ISS: if (rdy) begin m_dv = 0; m_phase = P_TRN; end
            P_TRN: begin
                if (m_h[m_dc] < ROWS) m_h[m_dc]++;
                m_cnt++;
                m_pl = 1 - m_pl;
`ifdef MOVE_CONTROLLER_RECENTER_EN
                m_cur = START_COL;
`endif
                if (m_cnt == COLS * ROWS) m_phase = P_DRAW;
                else if (go)              m_phase = P_HALT;
                else                      m_phase = P_SEL;
            end
            default: ;
        endcase
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(bit l, bit r, bit c, bit ng, bit go, bit rdy);
        @(negedge clk);
        left_pulse = l; right_pulse = r; confirm_pulse = c;
        new_game = ng; game_over_in = go; dif.drop_ready = rdy;
        @(posedge clk);
        #1;
        modelStep(l, r, c, ng, go, rdy);
    endtask

    task automatic checkModel(string tag);
        checkOutput({tag, ".cursor"},  int'(cursor_col),      m_cur);
        checkOutput({tag, ".player"},  int'(player),          m_pl);
        checkOutput({tag, ".valid"},   int'(dif.drop_valid),  m_dv);
        checkOutput({tag, ".col"},     int'(dif.drop_col),    m_dc);
        checkOutput({tag, ".row"},     int'(dif.drop_row),    m_dr);
        checkOutput({tag, ".dplayer"}, int'(dif.drop_player), m_dp);
        checkOutput({tag, ".err"},     int'(col_full_err),    m_err);
        checkOutput({tag, ".full"},    int'(board_full),      (m_phase == P_DRAW) ? 1 : 0);
    endtask

    task automatic doDrop(string tag);
        applyStimulus(0, 0, 1, 0, 0, 1); checkModel({tag, ".confirm"});
        applyStimulus(0, 0, 0, 0, 0, 1); checkModel({tag, ".accept"});
        applyStimulus(0, 0, 0, 0, 0, 1); checkModel({tag, ".turn"});
    endtask

    initial begin
        //              l r c ng go rdy  cur pl dv err bf dc dr dp
        tbl[0]  = mk(0,1,0,0,0,0, 4,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,1,0,0,0,0, 5,0,0,0,0,0,0,0);
        tbl[2]  = mk(0,1,0,0,0,0, 6,0,0,0,0,0,0,0);
        tbl[3]  = mk(0,1,0,0,0,0, 0,0,0,0,0,0,0,0);
        tbl[4]  = mk(1,0,0,0,0,0, 6,0,0,0,0,0,0,0);
        tbl[5]  = mk(1,0,0,0,0,0, 5,0,0,0,0,0,0,0);
        tbl[6]  = mk(1,0,0,0,0,0, 4,0,0,0,0,0,0,0);
        tbl[7]  = mk(1,0,0,0,0,0, 3,0,0,0,0,0,0,0);
        tbl[8]  = mk(0,0,1,0,0,0, 3,0,1,0,0,3,0,0);
        tbl[9]  = mk(0,0,0,0,0,0, 3,0,1,0,0,3,0,0);
        tbl[10] = mk(0,1,0,0,0,0, 3,0,1,0,0,3,0,0);
        tbl[11] = mk(0,0,0,0,0,1, 3,0,0,0,0,3,0,0);
        tbl[12] = mk(0,0,0,0,0,0, 3,1,0,0,0,3,0,0);
        tbl[13] = mk(1,0,1,0,0,0, 3,1,1,0,0,3,1,1);
        tbl[14] = mk(0,0,0,0,0,1, 3,1,0,0,0,3,1,1);
        tbl[15] = mk(0,0,0,0,0,0, 3,0,0,0,0,3,1,1);
        tbl[16] = mk(1,1,0,0,0,0, 3,0,0,0,0,3,1,1);
        tbl[17] = mk(0,0,0,1,0,0, 3,0,0,0,0,0,0,0);
        tbl[18] = mk(0,0,1,0,0,0, 3,0,1,0,0,3,0,0);
        tbl[19] = mk(0,0,0,1,0,0, 3,0,0,0,0,0,0,0);
        tbl[20] = mk(0,0,1,0,0,0, 3,0,1,0,0,3,0,0);
        tbl[21] = mk(0,0,0,0,0,1, 3,0,0,0,0,3,0,0);
        tbl[22] = mk(0,0,0,0,0,0, 3,1,0,0,0,3,0,0);
        tbl[23] = mk(0,0,1,0,1,0, 3,1,0,0,0,3,0,0);
        tbl[24] = mk(0,0,1,0,0,1, 3,1,0,0,0,3,0,0);
        tbl[25] = mk(0,1,0,0,0,0, 3,1,0,0,0,3,0,0);
        tbl[26] = mk(0,0,0,1,0,0, 3,0,0,0,0,0,0,0);

        reset = 1'b0;
        left_pulse = 0; right_pulse = 0; confirm_pulse = 0;
        new_game = 0; game_over_in = 0; dif.drop_ready = 0;
        modelReset();
        #12;
        checkOutput("reset.cursor", int'(cursor_col), START_COL);
        checkOutput("reset.player", int'(player), 0);
        checkOutput("reset.valid",  int'(dif.drop_valid), 0);
        checkOutput("reset.err",    int'(col_full_err), 0);
        checkOutput("reset.full",   int'(board_full), 0);
        checkOutput("reset.col",    int'(dif.drop_col), 0);
        checkOutput("reset.row",    int'(dif.drop_row), 0);
        checkOutput("reset.dplayer", int'(dif.drop_player), 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].ng, tbl[i].go, tbl[i].rdy);
            checkOutput({tag, ".cursor"},  int'(cursor_col),      tbl[i].cur);
            checkOutput({tag, ".player"},  int'(player),          tbl[i].pl);
            checkOutput({tag, ".valid"},   int'(dif.drop_valid),  tbl[i].dv);
            checkOutput({tag, ".err"},     int'(col_full_err),    tbl[i].err);
            checkOutput({tag, ".full"},    int'(board_full),      tbl[i].bf);
            checkOutput({tag, ".col"},     int'(dif.drop_col),    tbl[i].dc);
            checkOutput({tag, ".row"},     int'(dif.drop_row),    tbl[i].dr);
            checkOutput({tag, ".dplayer"}, int'(dif.drop_player), tbl[i].dp);
        end

        // Full column: six drops into column 0, then a rejected seventh
        for (int i = 0; i < START_COL; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0); checkModel("seek0");
        end
        for (int k = 0; k < ROWS; k++) doDrop($sformatf("col0.d%0d", k));
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkModel("col0.over");
        checkOutput("col0.err_pulse", int'(col_full_err), 1);
        checkOutput("col0.no_valid", int'(dif.drop_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkModel("col0.after");
        checkOutput("col0.err_clear", int'(col_full_err), 0);

        for (int c = 1; c < COLS; c++) begin
            applyStimulus(0, 1, 0, 0, 0, 0); checkModel($sformatf("seek%0d", c));
            for (int k = 0; k < ROWS; k++) doDrop($sformatf("col%0d.d%0d", c, k));
        end
        checkOutput("draw.full", int'(board_full), 1);
        applyStimulus(0, 1, 0, 0, 0, 0); checkModel("draw.right");
        applyStimulus(0, 0, 1, 0, 0, 1); checkModel("draw.confirm");
        checkOutput("draw.no_valid", int'(dif.drop_valid), 0);
        applyStimulus(0, 0, 0, 1, 0, 0); checkModel("draw.newgame");
        checkOutput("newgame.cursor", int'(cursor_col), START_COL);
        checkOutput("newgame.player", int'(player), 0);
        checkOutput("newgame.full", int'(board_full), 0);

        for (int n = 0; n < 2000; n++) begin
            bit l, r, c, ng, go, rdy;
            l   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 2) == 0);
            ng  = ($urandom_range(0, 299) == 0);
            go  = ($urandom_range(0, 249) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            applyStimulus(l, r, c, ng, go, rdy);
            checkModel($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
Consumes the one-cycle left/right/confirm pulses from the user-input stage and turns them into Connect-4 moves. Tracks the cursor column, per-column fill heights, whose turn it is and the total move count. On confirm into a non-full column it issues a valid/ready drop request (column, row, player) to the board-storage block. Sits between the input pulse stage and the board/win-check logic.

Parameters:
COLS, 7, number of board columns (≥2)
ROWS, 6, number of board rows (≥1)
COL_W, 3, width of column indices, ≥ clog2(COLS)
ROW_W, 3, width of row indices/heights, ≥ clog2(ROWS+1)
START_COL, 3, cursor column after reset/new game (< COLS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
left_pulse  in  1  one-cycle move-left request
right_pulse  in  1  one-cycle move-right request
confirm_pulse  in  1  one-cycle drop request
new_game  in  1  synchronous clear, level-sampled each cycle
game_over_in  in  1  win detected by downstream checker
drop_ready  in  1  board accepts drop this cycle
cursor_col  out  COL_W  current cursor column, registered
player  out  1  player to move: 0 = P1, 1 = P2
drop_valid  out  1  drop request valid
drop_col  out  COL_W  drop column
drop_row  out  ROW_W  landing row, 0 = bottom
drop_player  out  1  owner of dropped piece
col_full_err  out  1  one-cycle pulse: confirm on full column
board_full  out  1  high in DRAW state

Behaviour:
- Reset (reset low, async): state SELECT, cursor_col=START_COL, player=0, all heights=0, move count=0, drop_valid=0, col_full_err=0, board_full=0; drop_col/row/player=0.
- States: SELECT, ISSUE, TURN, DRAW, HALT. All outputs registered.
- SELECT, priority order per cycle:
  1. game_over_in=1 -> HALT.
  2. confirm_pulse=1 (overrides left/right): if height[cursor_col]==ROWS, col_full_err=1 next cycle, stay SELECT; else latch drop_col=cursor_col, drop_row=height[cursor_col], drop_player=player, drop_valid=1 next cycle, -> ISSUE.
  3. left_pulse xor right_pulse: cursor moves one column next cycle; left at 0 wraps to COLS-1, right at COLS-1 wraps to 0.
  4. left and right both high -> ignored.
- Latency: pulse at edge N -> cursor_col / drop_valid / col_full_err updated at edge N+1.
- ISSUE: drop_valid held high and drop_col/row/player held stable until drop_valid && drop_ready; transfer completes on that edge -> TURN with drop_valid=0. drop_ready while drop_valid=0 is ignored.
- TURN (exactly 1 cycle): height[drop_col]+1, move count+1, player toggles. Next: move count==COLS*ROWS -> DRAW; else game_over_in=1 -> HALT; else SELECT.
- DRAW: board_full=1; HALT: frozen. Both exit only via new_game or reset.
- Pulses arriving outside SELECT are discarded, never queued.
- new_game=1 in any state: next edge returns to reset values (sync); if in ISSUE, drop_valid drops and the request is aborted. Highest priority after reset.
- Move count width: clog2(COLS*ROWS+1); heights saturate at ROWS (never exceed).

Optional Feature:
MOVE_CONTROLLER_RECENTER_EN: when defined, TURN also sets cursor_col=START_COL so each player begins centred. When undefined, cursor_col is unchanged by a drop.

Test Plan:
- Reset, then 4 right_pulses -> cursor_col 3→4→5→6→0; 1 left_pulse -> 6.
- Confirm at col 3, drop_ready held 0 for 3 cycles then 1 -> drop_valid high 4 cycles with col=3,row=0,player=0 stable; after TURN player=1, next confirm at col 3 gives row=1.
- Fill col 0 with 6 drops (drop_ready=1), 7th confirm at col 0 -> col_full_err one-cycle pulse, no drop_valid, player unchanged.
- Same-cycle confirm+left at col 2 -> drop at col 2, cursor stays 2; left+right together -> no change.
- 42 accepted drops filling the board -> board_full=1 after last TURN; further pulses ignored; new_game -> cursor 3, player 0, board_full 0.
- game_over_in=1 in SELECT -> HALT, confirm ignored; new_game in ISSUE -> drop_valid low next cycle, heights unchanged.
